// File: rtl/wb8_wb32_bridge_pkg.sv
// Shared constants, FSM encoding and lane helpers for the 8-to-32-bit Wishbone bridge.
package wb8_wb32_bridge_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned WADR_W = 22;
    localparam int unsigned BADR_W = 24;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_BUS = 2'd1;
    localparam logic [1:0] ST_WR_BUS = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    localparam logic [LANE_W-1:0] LANE_LAST = 2'd3;
    localparam logic [0:LANES-1]  SEL_ALL   = 4'b1111;

    // Downstream request payload; lane 0 is the most significant byte.
    typedef struct packed {
        logic [0:WADR_W-1] adr;
        logic [0:WORD_W-1] dat;
        logic [0:LANES-1]  sel;
    } m_req_t;

    function automatic logic [0:WORD_W-1] lane_put(input logic [0:WORD_W-1] word,
                                                   input logic [LANE_W-1:0] lane,
                                                   input logic [0:BYTE_W-1] b);
        logic [0:WORD_W-1] r;
        r = word;
        r[{lane, 3'b000} +: BYTE_W] = b;
        return r;
    endfunction

    function automatic logic [0:BYTE_W-1] lane_get(input logic [0:WORD_W-1] word,
                                                   input logic [LANE_W-1:0] lane);
        return word[{lane, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/wb8_wb32_bridge.sv
// 8-bit Wishbone responder to 32-bit Wishbone initiator bridge with a write-combining
// buffer and an optional one-word read cache.
module wb8_wb32_bridge
    import wb8_wb32_bridge_pkg::*;
#(
    parameter int unsigned READ_CACHE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:BADR_W-1] wb_adr_i,
    input  logic [0:BYTE_W-1] wb_dat_i,
    output logic [0:BYTE_W-1] wb_dat_o,
    input  logic              wb_we_i,
    input  logic [0:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic [0:WADR_W-1] m_adr_o,
    output logic [0:WORD_W-1] m_dat_o,
    input  logic [0:WORD_W-1] m_dat_i,
    output logic [0:LANES-1]  m_sel_o,
    output logic              m_we_o,
    output logic              m_stb_o,
    output logic              m_cyc_o,
    input  logic              m_ack_i
);

    logic [1:0]          state, state_nx;
    logic [0:WADR_W-1]   word, wbuf_adr, cache_adr;
    logic [LANE_W-1:0]   lane, rd_lane;
    logic [0:WORD_W-1]   wbuf, wbuf_merged, cache;
    logic [0:LANES-1]    mask, mask_merged;
    logic                cache_vld, wr_ack;
    logic                req, hit, need_flush;
    logic                flush, go_wr_last, do_merge, do_hit, go_rd, clr_vld;
    m_req_t              m_req;

    assign word = wb_adr_i[0:WADR_W-1];
    assign lane = wb_adr_i[WADR_W:BADR_W-1];

    assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign hit  = (READ_CACHE != 0) && cache_vld && (cache_adr == word);
    // Pending bytes must reach memory before touching another word or missing on a read.
    assign need_flush = (mask != '0) && ((wbuf_adr != word) || (!wb_we_i && !hit));

    assign m_adr_o = m_req.adr;
    assign m_dat_o = m_req.dat;
    assign m_sel_o = m_req.sel;

    // Byte merge into the write-combining buffer.
    always_comb begin
        wbuf_merged       = lane_put(wbuf, lane, wb_dat_i);
        mask_merged       = mask;
        mask_merged[lane] = wb_sel_i[0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state and one-cycle action strobes.
    always_comb begin
        state_nx   = state;
        flush      = 1'b0;
        go_wr_last = 1'b0;
        do_merge   = 1'b0;
        do_hit     = 1'b0;
        go_rd      = 1'b0;
        clr_vld    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (need_flush) begin
                        flush    = 1'b1;
                        state_nx = ST_WR_BUS;
                    end else if (wb_we_i) begin
                        if (lane == LANE_LAST && mask_merged != '0) begin
                            go_wr_last = 1'b1;
                            state_nx   = ST_WR_BUS;
                        end else begin
                            do_merge = 1'b1;
                            state_nx = ST_ACK;
                        end
                    end else if (hit) begin
                        do_hit   = 1'b1;
                        state_nx = ST_ACK;
                    end else begin
                        go_rd    = 1'b1;
                        state_nx = ST_RD_BUS;
                    end
                end else if (!wb_cyc_i) begin
                    clr_vld = 1'b1;
                    if (mask != '0) begin
                        flush    = 1'b1;
                        state_nx = ST_WR_BUS;
                    end
                end
            end
            ST_RD_BUS: if (m_ack_i) state_nx = ST_ACK;
            ST_WR_BUS: if (m_ack_i) state_nx = wr_ack ? ST_ACK : ST_IDLE;
            ST_ACK:    state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_req     <= '0;
            wbuf      <= '0;
            wbuf_adr  <= '0;
            mask      <= '0;
            wr_ack    <= 1'b0;
            cache     <= '0;
            cache_adr <= '0;
            cache_vld <= 1'b0;
            rd_lane   <= '0;
        end else begin
            wb_ack_o <= (state_nx == ST_ACK);
            m_cyc_o  <= (state_nx == ST_RD_BUS) || (state_nx == ST_WR_BUS);
            m_stb_o  <= (state_nx == ST_RD_BUS) || (state_nx == ST_WR_BUS);
            m_we_o   <= (state_nx == ST_WR_BUS);

            if (clr_vld) cache_vld <= 1'b0;

            if (flush) begin
                m_req  <= '{adr: wbuf_adr, dat: wbuf, sel: mask};
                mask   <= '0;
                wr_ack <= 1'b0;
            end

            if (go_wr_last) begin
                m_req    <= '{adr: word, dat: wbuf_merged, sel: mask_merged};
                wbuf     <= wbuf_merged;
                wbuf_adr <= word;
                mask     <= '0;
                wr_ack   <= 1'b1;
            end

            if (do_merge) begin
                wbuf     <= wbuf_merged;
                wbuf_adr <= word;
                mask     <= mask_merged;
            end

            // Keep the cached copy coherent with upstream writes.
            if ((do_merge || go_wr_last) && cache_vld && cache_adr == word && wb_sel_i[0])
                cache <= lane_put(cache, lane, wb_dat_i);

            if (do_hit) wb_dat_o <= lane_get(cache, lane);

            if (go_rd) begin
                m_req.adr <= word;
                m_req.sel <= SEL_ALL;
                rd_lane   <= lane;
            end

            if (state == ST_RD_BUS && m_ack_i) begin
                cache     <= m_dat_i;
                cache_adr <= m_req.adr;
                cache_vld <= 1'b1;
                wb_dat_o  <= lane_get(m_dat_i, rd_lane);
            end
        end
    end

endmodule

// File: tb/tb_wb8_wb32_bridge.sv
// Scoreboard bench for wb8_wb32_bridge: cached and uncached instances, directed byte traffic.
module tb_wb8_wb32_bridge;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    always #5 clk = ~clk;

    logic [0:23] wb_adr  [2];
    logic [0:7]  wb_wdat [2];
    logic [0:7]  wb_rdat [2];
    logic [0:0]  wb_sel  [2];
    logic        wb_we   [2];
    logic        wb_stb  [2];
    logic        wb_cyc  [2];
    logic        wb_ack  [2];
    logic [0:21] m_adr   [2];
    logic [0:31] m_wdat  [2];
    logic [0:31] m_rdat  [2];
    logic [0:3]  m_sel   [2];
    logic        m_we    [2];
    logic        m_stb   [2];
    logic        m_cyc   [2];
    logic        m_ack   [2];
    logic [31:0] rd_word [2];

    assign m_rdat[0] = rd_word[0];
    assign m_rdat[1] = rd_word[1];

    wb8_wb32_bridge #(.READ_CACHE(1)) u_cached (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr[0]), .wb_dat_i(wb_wdat[0]), .wb_dat_o(wb_rdat[0]),
        .wb_we_i(wb_we[0]), .wb_sel_i(wb_sel[0]), .wb_stb_i(wb_stb[0]),
        .wb_cyc_i(wb_cyc[0]), .wb_ack_o(wb_ack[0]),
        .m_adr_o(m_adr[0]), .m_dat_o(m_wdat[0]), .m_dat_i(m_rdat[0]), .m_sel_o(m_sel[0]),
        .m_we_o(m_we[0]), .m_stb_o(m_stb[0]), .m_cyc_o(m_cyc[0]), .m_ack_i(m_ack[0])
    );

    wb8_wb32_bridge #(.READ_CACHE(0)) u_uncached (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr[1]), .wb_dat_i(wb_wdat[1]), .wb_dat_o(wb_rdat[1]),
        .wb_we_i(wb_we[1]), .wb_sel_i(wb_sel[1]), .wb_stb_i(wb_stb[1]),
        .wb_cyc_i(wb_cyc[1]), .wb_ack_o(wb_ack[1]),
        .m_adr_o(m_adr[1]), .m_dat_o(m_wdat[1]), .m_dat_i(m_rdat[1]), .m_sel_o(m_sel[1]),
        .m_we_o(m_we[1]), .m_stb_o(m_stb[1]), .m_cyc_o(m_cyc[1]), .m_ack_i(m_ack[1])
    );

    typedef struct {
        int          d;
        logic        we;
        logic [21:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } mexp_t;

    typedef struct {
        int         d;
        logic [7:0] b;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];
    int checks = 0;
    int passed = 0;
    int hs_cnt [2] = '{0, 0};
    int ack_cnt[2] = '{0, 0};

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int l = 0; l < 4; l++)
            if (sel[3-l]) m[31-8*l -: 8] = 8'hFF;
        return m;
    endfunction

    task automatic push_m(input int d, input logic we, input logic [21:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        mexp_t e;
        e.d = d; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
        mq.push_back(e);
    endtask

    task automatic push_r(input int d, input logic [7:0] b);
        rexp_t r;
        r.d = d; r.b = b;
        rq.push_back(r);
    endtask

    // Downstream responder: one-cycle-delayed ack unless stalled.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) m_ack[d] <= 1'b0;
            else       m_ack[d] <= m_cyc[d] && m_stb[d] && !m_ack[d] && !stall;
        end
    end

    // Monitor: pops and compares on every downstream handshake and upstream read ack.
    always @(negedge clk) begin : mon
        mexp_t e;
        rexp_t r;
        for (int d = 0; d < 2; d++) begin
            if (m_cyc[d] && m_stb[d] && m_ack[d]) begin
                hs_cnt[d]++;
                if (mq.size() == 0) begin
                    checks++;
                    $display("FAIL m_unexpected: dut%0d adr %h we %b with nothing expected", d, m_adr[d], m_we[d]);
                end else begin
                    e = mq.pop_front();
                    chk("m_dut", 32'(d), 32'(e.d));
                    chk("m_we", 32'(m_we[d]), 32'(e.we));
                    chk("m_adr", 32'(m_adr[d]), 32'(e.adr));
                    chk("m_sel", 32'(m_sel[d]), 32'(e.sel));
                    if (e.we) chk("m_dat", 32'(m_wdat[d]) & byte_mask(e.sel), e.dat & byte_mask(e.sel));
                end
            end
            if (wb_ack[d]) begin
                ack_cnt[d]++;
                if (!wb_we[d]) begin
                    if (rq.size() == 0) begin
                        checks++;
                        $display("FAIL rd_unexpected: dut%0d byte %h with nothing expected", d, wb_rdat[d]);
                    end else begin
                        r = rq.pop_front();
                        chk("rd_dut", 32'(d), 32'(r.d));
                        chk("rd_byte", 32'(wb_rdat[d]), 32'(r.b));
                    end
                end
            end
        end
    end

    task automatic bus(input int d, input logic we, input logic [23:0] a, input logic [7:0] b,
                       output int lat);
        logic got;
        wb_cyc[d] = 1'b1; wb_stb[d] = 1'b1; wb_we[d] = we;
        wb_adr[d] = a; wb_wdat[d] = b; wb_sel[d] = 1'b1;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (wb_ack[d]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL ack_timeout: dut%0d adr %h no ack in 100 cycles", d, a);
        end
        @(posedge clk); #1;
        wb_stb[d] = 1'b0;
    endtask

    task automatic drop_cyc(input int d);
        wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int hs_before;
        logic got;
        logic [7:0] bb [4];
        bb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        reset = 1'b1; stall = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0; wb_we[d] = 1'b0;
            wb_adr[d] = '0; wb_wdat[d] = '0; wb_sel[d] = 1'b1; rd_word[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_ack", 32'(wb_ack[0]), 0);
        chk("rst_wb_dat", 32'(wb_rdat[0]), 0);
        chk("rst_m_cyc", 32'(m_cyc[0]), 0);
        chk("rst_m_stb", 32'(m_stb[0]), 0);
        chk("rst_m_sel", 32'(m_sel[0]), 0);
        chk("rst_m_adr", 32'(m_adr[0]), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Four combined byte writes become one full-word write.
        push_m(0, 1'b1, 22'h40, 32'h12345678, 4'b1111);
        bus(0, 1'b1, 24'h000100, 8'h12, lat); chk("w_lane0_lat", 32'(lat), 1);
        bus(0, 1'b1, 24'h000101, 8'h34, lat);
        bus(0, 1'b1, 24'h000102, 8'h56, lat);
        bus(0, 1'b1, 24'h000103, 8'h78, lat); chk("w_lane3_lat", 32'(lat), 3);
        chk("w4_ack_cnt", 32'(ack_cnt[0]), 4);
        chk("w4_hs_cnt", 32'(hs_cnt[0]), 1);
        drop_cyc(0);

        // One downstream read, then three cache hits.
        rd_word[0] = 32'hCAFEBABE;
        push_m(0, 1'b0, 22'h80, 32'h0, 4'b1111);
        push_r(0, 8'hCA); bus(0, 1'b0, 24'h000200, 8'h00, lat); chk("rd_miss_lat", 32'(lat), 3);
        push_r(0, 8'hFE); bus(0, 1'b0, 24'h000201, 8'h00, lat); chk("rd_hit1_lat", 32'(lat), 1);
        push_r(0, 8'hBA); bus(0, 1'b0, 24'h000202, 8'h00, lat); chk("rd_hit2_lat", 32'(lat), 1);
        push_r(0, 8'hBE); bus(0, 1'b0, 24'h000203, 8'h00, lat); chk("rd_hit3_lat", 32'(lat), 1);
        chk("rd_hs_cnt", 32'(hs_cnt[0]), 2);
        chk("rd_ack_cnt", 32'(ack_cnt[0]), 8);

        // Partial word flushed autonomously when the cycle ends.
        push_m(0, 1'b1, 22'h100, 32'hAABB0000, 4'b1100);
        bus(0, 1'b1, 24'h000400, 8'hAA, lat);
        bus(0, 1'b1, 24'h000401, 8'hBB, lat);
        chk("part_no_early_flush", 32'(hs_cnt[0]), 2);
        drop_cyc(0);
        chk("part_flush_hs", 32'(hs_cnt[0]), 3);
        chk("part_flush_no_ack", 32'(ack_cnt[0]), 10);

        // Pending write flushed ahead of a read miss to another word.
        rd_word[0] = 32'h11223344;
        push_m(0, 1'b1, 22'h40, 32'h5A000000, 4'b1000);
        push_m(0, 1'b0, 22'hC0, 32'h0, 4'b1111);
        push_r(0, 8'h11);
        bus(0, 1'b1, 24'h000100, 8'h5A, lat);
        bus(0, 1'b0, 24'h000300, 8'h00, lat);
        chk("flush_rd_hs", 32'(hs_cnt[0]), 5);

        // Write into the cached word updates the hit data.
        bus(0, 1'b1, 24'h000302, 8'h99, lat);
        push_r(0, 8'h99);
        bus(0, 1'b0, 24'h000302, 8'h00, lat); chk("coh_hit_lat", 32'(lat), 1);
        chk("coh_no_rd", 32'(hs_cnt[0]), 5);
        push_m(0, 1'b1, 22'hC0, 32'h00009900, 4'b0010);
        drop_cyc(0);
        chk("coh_flush_hs", 32'(hs_cnt[0]), 6);
        chk("coh_ack_cnt", 32'(ack_cnt[0]), 14);

        // Reset during a stalled downstream write discards it.
        bus(0, 1'b1, 24'h000500, 8'h77, lat);
        stall = 1'b1;
        wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b1;
        wb_adr[0] = 24'h000503; wb_wdat[0] = 8'h88;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (m_stb[0]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL wr_stb_timeout: m_stb_o never rose");
        end
        chk("stall_m_sel", 32'(m_sel[0]), 32'h9);
        chk("stall_m_we", 32'(m_we[0]), 1);
        hs_before = hs_cnt[0];
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rrst_m_cyc", 32'(m_cyc[0]), 0);
        chk("rrst_m_stb", 32'(m_stb[0]), 0);
        chk("rrst_m_we", 32'(m_we[0]), 0);
        chk("rrst_m_sel", 32'(m_sel[0]), 0);
        chk("rrst_m_adr", 32'(m_adr[0]), 0);
        chk("rrst_m_dat", 32'(m_wdat[0]), 0);
        chk("rrst_wb_ack", 32'(wb_ack[0]), 0);
        chk("rrst_wb_dat", 32'(wb_rdat[0]), 0);
        wb_stb[0] = 1'b0; wb_cyc[0] = 1'b0; stall = 1'b0;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rrst_no_flush", 32'(hs_cnt[0]), 32'(hs_before));
        chk("rrst_m_cyc_idle", 32'(m_cyc[0]), 0);

        // Without the cache every byte read goes downstream.
        rd_word[1] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            push_m(1, 1'b0, 22'h180, 32'h0, 4'b1111);
            push_r(1, bb[i]);
            bus(1, 1'b0, 24'h000600 + 24'(i), 8'h00, lat);
            chk("nc_rd_lat", 32'(lat), 3);
        end
        chk("nc_hs_cnt", 32'(hs_cnt[1]), 4);
        drop_cyc(1);

        chk("mq_empty", 32'(mq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
